vga_ctrl: RTL and testbench

Parametrised VGA controller: framebuffer VRAM with a CPU bus port, a sync/timing generator and pixel scanout. CPU and scanout share one single-port VRAM through a fixed two-phase time-slot scheme, so neither can starve the other. It sits on the CPU memory bus in place of the bare VRAM block and drives the VGA DAC/connector pins.

---
 rtl/vga_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_vga_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_ctrl
//  Purpose  : VGA controller with a CPU-accessible framebuffer VRAM, a
//             sync/timing generator and pixel scanout. The single-port VRAM
//             is time-shared: phase 0 of every pixel is the video fetch slot,
//             phase 1 is the CPU slot.
//  Options  : VGA_DOUBLE_SCAN_EN - when defined, every framebuffer row is
//             shown on two consecutive lines (line base steps after odd
//             visible lines only).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_ctrl #(
  parameter int AW     = 17,
  parameter int WIDTH  = 32,
  parameter int BPP    = 8,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [AW-1:0]    addr,
  input  logic             n_we,
  input  logic             n_oe,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             ack,
  output logic [BPP-1:0]   pix,
  output logic             de,
  output logic             hsync,
  output logic             vsync
);

  // --------------------------------------------------------------------------
  // Derived geometry
  // --------------------------------------------------------------------------
  localparam int DEPTH   = 2**AW;
  localparam int PPW     = WIDTH / BPP;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int WPL     = H_VIS / PPW;           // words per framebuffer row

  // Counter widths leave room for the total itself so the sync end bounds fit
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int SW = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int XW = $clog2(WPL + 1);

  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_START = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_START = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [SW-1:0] SUB_LAST = SW'(PPW - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(WPL);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             phase;      // 0 = video slot, 1 = CPU slot
  logic [HW-1:0]    hc;
  logic [VW-1:0]    vc;
  logic [SW-1:0]    sub;        // pixel index inside the current word (hc % PPW)
  logic [XW-1:0]    word_idx;   // word index inside the current row (hc / PPW)
  logic [AW-1:0]    line_base;  // VRAM address of the current row
  logic [WIDTH-1:0] word_q;     // word being shifted out to the screen

  logic [WIDTH-1:0] mem [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic             h_vis;
  logic             v_vis;
  logic             vis;
  logic             fetch;
  logic             cpu_wr;
  logic             cpu_rd;
  logic             line_end;
  logic             frame_end;
  logic             base_step;
  logic             hs_active;
  logic             vs_active;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_rd;

  // Slot decode, single shared VRAM address mux and sync windows
  always_comb begin
    h_vis     = (hc < H_VIS_C);
    v_vis     = (vc < V_VIS_C);
    vis       = h_vis && v_vis;
    fetch     = !phase && vis && (sub == '0);
    cpu_wr    = phase && !n_we;
    cpu_rd    = phase && n_we && !n_oe;      // write wins when both are low
    line_end  = phase && (hc == H_LAST);
    frame_end = line_end && (vc == V_LAST);
`ifdef VGA_DOUBLE_SCAN_EN
    base_step = v_vis && vc[0];              // row repeats on even/odd line pair
`else
    base_step = v_vis;
`endif
    hs_active = (hc >= HS_START) && (hc < HS_END);
    vs_active = (vc >= VS_START) && (vc < VS_END);
    ram_addr  = phase ? addr : (line_base + AW'(word_idx));
  end

  assign ram_rd = mem[ram_addr];

  // VRAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (cpu_wr) begin
      mem[ram_addr] <= in;
    end
  end

  // Slot phase, beam counters and row base address
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase     <= 1'b0;
      hc        <= '0;
      vc        <= '0;
      sub       <= '0;
      word_idx  <= '0;
      line_base <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (line_end) begin
          hc       <= '0;
          sub      <= '0;
          word_idx <= '0;
          if (frame_end) begin
            vc        <= '0;
            line_base <= '0;
          end else begin
            vc <= vc + 1'b1;
            if (base_step) begin
              line_base <= line_base + ROW_STEP;
            end
          end
        end else begin
          hc <= hc + 1'b1;
          if (h_vis) begin
            if (sub == SUB_LAST) begin
              sub      <= '0;
              word_idx <= word_idx + 1'b1;
            end else begin
              sub <= sub + 1'b1;
            end
          end
        end
      end
    end
  end

  // Video fetch, pixel/sync output registers and CPU handshake
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_q <= '0;
      out    <= '0;
      ack    <= 1'b0;
      pix    <= '0;
      de     <= 1'b0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
    end else begin
      ack <= 1'b0;
      if (fetch) begin
        word_q <= ram_rd;
      end
      if (phase) begin
        ack   <= cpu_wr || cpu_rd;
        if (cpu_rd) begin
          out <= ram_rd;
        end
        // All four video outputs describe pixel hc, one pixel behind the beam
        de    <= vis;
        pix   <= vis ? word_q[BPP*int'(sub) +: BPP] : '0;
        hsync <= !hs_active;
        vsync <= !vs_active;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_ctrl
//  Purpose  : Self-checking bench for vga_ctrl. A default-geometry instance
//             covers the CPU port and horizontal timing; a tiny-geometry
//             instance covers whole-frame timing and row addressing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_ctrl;

  logic clk;
  logic n_rst;

  // Default-parameter instance
  logic [16:0] d_addr;
  logic        d_n_we, d_n_oe;
  logic [31:0] d_in, d_out;
  logic        d_ack, d_de, d_hs, d_vs;
  logic [7:0]  d_pix;

  // Small-geometry instance (H 8/1/2/1, V 4/1/1/1)
  logic [3:0]  s_addr;
  logic        s_n_we, s_n_oe;
  logic [31:0] s_in, s_out;
  logic        s_ack, s_de, s_hs, s_vs;
  logic [7:0]  s_pix;

  int cyc;
  int passed = 0;
  int total  = 0;

  vga_ctrl u_dflt (
    .clk(clk), .n_rst(n_rst), .addr(d_addr), .n_we(d_n_we), .n_oe(d_n_oe),
    .in(d_in), .out(d_out), .ack(d_ack), .pix(d_pix), .de(d_de),
    .hsync(d_hs), .vsync(d_vs)
  );

  vga_ctrl #(
    .AW(4), .WIDTH(32), .BPP(8),
    .H_VIS(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clk(clk), .n_rst(n_rst), .addr(s_addr), .n_we(s_n_we), .n_oe(s_n_oe),
    .in(s_in), .out(s_out), .ack(s_ack), .pix(s_pix), .de(s_de),
    .hsync(s_hs), .vsync(s_vs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: edge k after reset release reads as cyc == k at the next negedge
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc < k && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) chk("wait_cyc", cyc, k);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_d_out"}, d_out, 32'h0);
    chk({tag, "_d_ack"}, 32'(d_ack), 32'h0);
    chk({tag, "_d_pix"}, 32'(d_pix), 32'h0);
    chk({tag, "_d_de"},  32'(d_de),  32'h0);
    chk({tag, "_d_hs"},  32'(d_hs),  32'h1);
    chk({tag, "_d_vs"},  32'(d_vs),  32'h1);
    chk({tag, "_s_de"},  32'(s_de),  32'h0);
    chk({tag, "_s_hs"},  32'(s_hs),  32'h1);
    chk({tag, "_s_vs"},  32'(s_vs),  32'h1);
  endtask

  // One CPU access, called at a negedge; returns read data once ACK is seen
  task automatic cpu(input bit s, input bit wr, input int a, input logic [31:0] data,
                     output logic [31:0] rdata);
    int  lat = 0;
    bit  got = 0;
    logic [31:0] av;
    av = a;
    if (s) begin
      s_addr = av[3:0];
      s_in   = data;
      if (wr) s_n_we = 1'b0; else s_n_oe = 1'b0;
    end else begin
      d_addr = av[16:0];
      d_in   = data;
      if (wr) d_n_we = 1'b0; else d_n_oe = 1'b0;
    end
    while (!got && lat < 4) begin
      @(negedge clk);
      lat++;
      got = s ? s_ack : d_ack;
    end
    rdata = s ? s_out : d_out;
    if (s) begin s_n_we = 1'b1; s_n_oe = 1'b1; end
    else   begin d_n_we = 1'b1; d_n_oe = 1'b1; end
    chk("ack_latency_ok", 32'(got && lat <= 2), 32'h1);
  endtask

  typedef struct {
    bit         s;      // 1 = small instance
    int         k;      // edge index after reset release
    logic [7:0] pix;
    bit         de;
    bit         hs;
    bit         vs;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  initial begin
    logic [31:0] rd;
    int acks;

    n_rst = 1'b0;
    d_addr = '0; d_n_we = 1'b1; d_n_oe = 1'b1; d_in = '0;
    s_addr = '0; s_n_we = 1'b1; s_n_oe = 1'b1; s_in = '0;

    // Expected scanout: pixel (hc,vc) is registered at edge 2*(vc*H_TOTAL+hc)+2
    tbl[0]  = '{0, 2,    8'h11, 1, 1, 1};
    tbl[1]  = '{1, 2,    8'h01, 1, 1, 1};
    tbl[2]  = '{0, 4,    8'h22, 1, 1, 1};
    tbl[3]  = '{0, 6,    8'h33, 1, 1, 1};
    tbl[4]  = '{0, 8,    8'h44, 1, 1, 1};
    tbl[5]  = '{1, 8,    8'h04, 1, 1, 1};
    tbl[6]  = '{1, 10,   8'h05, 1, 1, 1};
    tbl[7]  = '{1, 16,   8'h08, 1, 1, 1};
    tbl[8]  = '{1, 18,   8'h00, 0, 1, 1};
    tbl[9]  = '{1, 20,   8'h00, 0, 0, 1};
    tbl[10] = '{1, 22,   8'h00, 0, 0, 1};
    tbl[11] = '{1, 24,   8'h00, 0, 1, 1};
`ifdef VGA_DOUBLE_SCAN_EN
    tbl[12] = '{1, 26,   8'h01, 1, 1, 1};
    tbl[13] = '{1, 28,   8'h02, 1, 1, 1};
    tbl[14] = '{1, 30,   8'h03, 1, 1, 1};
    tbl[15] = '{1, 32,   8'h04, 1, 1, 1};
    tbl[16] = '{1, 50,   8'h0D, 1, 1, 1};
    tbl[17] = '{1, 80,   8'h0A, 1, 1, 1};
`else
    tbl[12] = '{1, 26,   8'h0D, 1, 1, 1};
    tbl[13] = '{1, 28,   8'h0C, 1, 1, 1};
    tbl[14] = '{1, 30,   8'h0B, 1, 1, 1};
    tbl[15] = '{1, 32,   8'h0A, 1, 1, 1};
    tbl[16] = '{1, 50,   8'h21, 1, 1, 1};
    tbl[17] = '{1, 80,   8'h34, 1, 1, 1};
`endif
    tbl[18] = '{1, 98,   8'h00, 0, 1, 1};
    tbl[19] = '{1, 122,  8'h00, 0, 1, 0};
    tbl[20] = '{1, 140,  8'h00, 0, 0, 0};
    tbl[21] = '{1, 146,  8'h00, 0, 1, 1};
    tbl[22] = '{1, 170,  8'h01, 1, 1, 1};
    tbl[23] = '{1, 188,  8'h00, 0, 0, 1};
    tbl[24] = '{0, 1313, 8'h00, 0, 1, 1};
    tbl[25] = '{0, 1314, 8'h00, 0, 0, 1};
    tbl[26] = '{0, 1505, 8'h00, 0, 0, 1};
    tbl[27] = '{0, 1506, 8'h00, 0, 1, 1};

    repeat (3) @(negedge clk);
    check_reset("rst0");
    n_rst = 1'b1;
    @(negedge clk);

    // Load framebuffers and exercise the CPU port
    cpu(0, 1, 0,     32'h44332211, rd);
    cpu(0, 1, 'h123, 32'hDEADBEEF, rd);
    cpu(0, 0, 'h123, 32'h0, rd);
    chk("read_0x123", rd, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("out_hold", d_out, 32'hDEADBEEF);
    cpu(1, 1, 0, 32'h04030201, rd);
    cpu(1, 1, 1, 32'h08070605, rd);
    cpu(1, 1, 2, 32'h0A0B0C0D, rd);
    cpu(1, 1, 3, 32'h1A1B1C1D, rd);
    cpu(1, 1, 4, 32'h24232221, rd);
    cpu(1, 1, 5, 32'h28272625, rd);
    cpu(1, 1, 6, 32'h34333231, rd);
    cpu(1, 1, 7, 32'h38373635, rd);
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-line, between clock edges
    #3 n_rst = 1'b0;
    #1 check_reset("async_rst");
    @(negedge clk);
    n_rst = 1'b1;

    fork
      begin
        for (int i = 0; i < NV; i++) begin
          wait_cyc(tbl[i].k);
          if (tbl[i].s) begin
            chk($sformatf("s_pix[%0d]", i), 32'(s_pix), 32'(tbl[i].pix));
            chk($sformatf("s_de[%0d]", i),  32'(s_de),  32'(tbl[i].de));
            chk($sformatf("s_hs[%0d]", i),  32'(s_hs),  32'(tbl[i].hs));
            chk($sformatf("s_vs[%0d]", i),  32'(s_vs),  32'(tbl[i].vs));
          end else begin
            chk($sformatf("d_pix[%0d]", i), 32'(d_pix), 32'(tbl[i].pix));
            chk($sformatf("d_de[%0d]", i),  32'(d_de),  32'(tbl[i].de));
            chk($sformatf("d_hs[%0d]", i),  32'(d_hs),  32'(tbl[i].hs));
            chk($sformatf("d_vs[%0d]", i),  32'(d_vs),  32'(tbl[i].vs));
          end
        end
      end
      begin
        // Write request held low for 6 cycles during scanout
        wait_cyc(34);
        acks   = 0;
        s_addr = 4'd2;
        s_in   = 32'h0A0B0C0D;
        s_n_we = 1'b0;
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          if (s_ack) acks++;
          if (j == 5) s_n_we = 1'b1;
        end
        chk("held_we_ack_count", acks, 3);
      end
    join

    cpu(1, 0, 2, 32'h0, rd);
    chk("s_read_after_burst", rd, 32'h0A0B0C0D);
    cpu(0, 0, 'h123, 32'h0, rd);
    chk("vram_kept_over_reset", rd, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
